// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- handshaked sequential ALU
//
// Keeps the 4-bit ALUop encoding, operand convention and ADD/SUB flags of the
// single-cycle datapath ALU. Adds SLTU and iterative unsigned MUL/MULHU/DIVU/
// REMU. Results are registered and returned over a valid/ready interface, so
// the core can stall on long-latency operations.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   operation request
//   in_ready   block can accept a request (high only in IDLE)
//   A          operand A; the shift amount for shifts
//   B          operand B; the value shifted for shifts
//   ALUop      operation select
//   out_valid  Result and flags are valid (high only in DONE)
//   out_ready  consumer accepts the result
//   Result     registered result
//   Zero       Result == 0
//   Overflow   signed overflow, ADD/SUB only
//   CarryOut   ADD: carry out of MSB; SUB: borrow (A <u B); otherwise 0
//
// Latency: single-cycle ops 1, MUL/MULHU/DIVU/REMU DATA_WIDTH+1 cycles from
// the accept edge to out_valid. No accept while a result is pending.
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [3:0]            ALUop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  Zero,
    output logic                  Overflow,
    output logic                  CarryOut
);

    localparam int unsigned SHAMT_W = $clog2(DATA_WIDTH);
    localparam int unsigned CNT_W   = SHAMT_W + 1;
    localparam int unsigned W       = DATA_WIDTH;

    localparam logic [3:0] OpAnd   = 4'b0000;
    localparam logic [3:0] OpOr    = 4'b0001;
    localparam logic [3:0] OpAdd   = 4'b0010;
    localparam logic [3:0] OpSll   = 4'b0011;
    localparam logic [3:0] OpSra   = 4'b0100;
    localparam logic [3:0] OpSrl   = 4'b0101;
    localparam logic [3:0] OpSub   = 4'b0110;
    localparam logic [3:0] OpSlt   = 4'b0111;
    localparam logic [3:0] OpXor   = 4'b1000;
    localparam logic [3:0] OpSltu  = 4'b1001;
    localparam logic [3:0] OpMul   = 4'b1010;
    localparam logic [3:0] OpMulhu = 4'b1011;
    localparam logic [3:0] OpDivu  = 4'b1100;
    localparam logic [3:0] OpRemu  = 4'b1101;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e          state_q;
    logic [2*W-1:0]  acc_q;     // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
    logic [W-1:0]    b_q;
    logic [3:0]      op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]    result_q;
    logic            zero_q;
    logic            ovf_q;
    logic            cout_q;

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign Result    = result_q;
    assign Zero      = zero_q;
    assign Overflow  = ovf_q;
    assign CarryOut  = cout_q;

    // ------------------------------------------------------------------
    // Single-cycle datapath, evaluated on the live request operands.
    // ------------------------------------------------------------------
    logic [SHAMT_W-1:0] shamt;
    logic [W:0]         add_full;
    logic [W-1:0]       sub_diff;
    logic [W-1:0]       sc_res;
    logic               sc_ovf;
    logic               sc_cout;
    logic               op_is_multi;

    always_comb begin
        shamt    = A[SHAMT_W-1:0];
        add_full = {1'b0, A} + {1'b0, B};
        sub_diff = A - B;
        sc_res   = '0;
        sc_ovf   = 1'b0;
        sc_cout  = 1'b0;
        case (ALUop)
            OpAnd: sc_res = A & B;
            OpOr:  sc_res = A | B;
            OpXor: sc_res = A ^ B;
            OpAdd: begin
                sc_res  = add_full[W-1:0];
                sc_cout = add_full[W];
                // Same-sign operands producing a different-sign sum.
                sc_ovf  = (A[W-1] == B[W-1]) && (add_full[W-1] != A[W-1]);
            end
            OpSub: begin
                sc_res  = sub_diff;
                sc_cout = (A < B);
                // Opposite-sign operands, difference sign differs from A.
                // Covers B = most-negative value without special casing.
                sc_ovf  = (A[W-1] != B[W-1]) && (sub_diff[W-1] != A[W-1]);
            end
            OpSll: sc_res = B << shamt;
            OpSrl: sc_res = B >> shamt;
            OpSra: sc_res = W'($signed(B) >>> shamt);
            OpSlt: sc_res = {{(W-1){1'b0}}, ($signed(A) < $signed(B))};
            OpSltu: sc_res = {{(W-1){1'b0}}, (A < B)};
            default: sc_res = '0;   // reserved codes and iterative ops
        endcase
    end

    always_comb begin
        op_is_multi = (ALUop == OpMul) || (ALUop == OpMulhu) ||
                      (ALUop == OpDivu) || (ALUop == OpRemu);
    end

    // ------------------------------------------------------------------
    // One iteration of shift-add multiply or restoring divide.
    // ------------------------------------------------------------------
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    logic [W:0]     div_shift;
    logic [W:0]     div_diff;
    logic [2*W-1:0] div_next;
    logic [2*W-1:0] step_next;
    logic [W-1:0]   step_res;
    logic           op_is_div;
    logic           op_takes_hi;

    always_comb begin
        op_is_div   = (op_q == OpDivu) || (op_q == OpRemu);
        op_takes_hi = (op_q == OpMulhu) || (op_q == OpRemu);

        // Add multiplicand into the upper half when the current multiplier
        // LSB is set, then shift the whole accumulator right by one.
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});
        mul_next = {mul_sum, acc_q[W-1:1]};

        // Shift next dividend bit into the remainder and try a subtract.
        // div_diff[W] set means the trial went negative, so restore.
        // Divide by zero naturally yields all-ones quotient and remainder = A.
        div_shift = acc_q[2*W-1:W-1];
        div_diff  = div_shift - {1'b0, b_q};
        if (div_diff[W]) begin
            div_next = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
        end else begin
            div_next = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
        end

        step_next = op_is_div ? div_next : mul_next;
        step_res  = op_takes_hi ? step_next[2*W-1:W] : step_next[W-1:0];
    end

    // ------------------------------------------------------------------
    // Control FSM with registered result and flags.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_q <= ALUop;
                        b_q  <= B;
                        if (op_is_multi) begin
                            acc_q   <= {{W{1'b0}}, A};
                            cnt_q   <= CNT_W'(DATA_WIDTH);
                            state_q <= StBusy;
                        end else begin
                            // Zero tracks exactly the value written into Result.
                            result_q <= sc_res;
                            zero_q   <= (sc_res == '0);
                            ovf_q    <= sc_ovf;
                            cout_q   <= sc_cout;
                            state_q  <= StDone;
                        end
                    end
                end
                StBusy: begin
                    acc_q <= step_next;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        result_q <= step_res;
                        zero_q   <= (step_res == '0);
                        ovf_q    <= 1'b0;
                        cout_q   <= 1'b0;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    // No new accept here; the block returns to IDLE first.
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- scoreboard bench for alu_seq (DATA_WIDTH = 32).
// The driver pushes the hand-computed response when a request is accepted;
// an independent monitor pops and compares whenever out_valid is presented.
// ---------------------------------------------------------------------------
module tb_alu_seq;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [3:0]    op = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  result;
    logic          zero;
    logic          ovf;
    logic          cout;

    alu_seq #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .ALUop     (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (result),
        .Zero      (zero),
        .Overflow  (ovf),
        .CarryOut  (cout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         ov;
        logic         co;
        int           lat;
        int           acc;
        string        name;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   seen = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Monitor: compares whatever the DUT presents against the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    fail_now("spurious out_valid");
                end else begin
                    if (!seen) begin
                        chk({q[0].name, " latency"}, cyc - q[0].acc + 1, q[0].lat);
                        seen = 1'b1;
                    end
                    chk({q[0].name, " Result"}, result, q[0].res);
                    chk({q[0].name, " Zero"}, zero, q[0].z);
                    chk({q[0].name, " Overflow"}, ovf, q[0].ov);
                    chk({q[0].name, " CarryOut"}, cout, q[0].co);
                    chk({q[0].name, " in_ready in DONE"}, in_ready, 0);
                    if (out_ready) begin
                        void'(q.pop_front());
                        seen = 1'b0;
                    end
                end
            end else if (q.size() > 0 && cyc >= q[0].acc) begin
                chk({q[0].name, " in_ready while busy"}, in_ready, 0);
            end
        end
    end

    task automatic issue(input string name, input logic [3:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] r,
                         input logic z, input logic ov, input logic co);
        exp_t e;
        bit   ok = 1'b0;
        @(posedge clk);
        #1;
        a = x;
        b = y;
        op = o;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            fail_now({name, " accept"});
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e.res  = r;
        e.z    = z;
        e.ov   = ov;
        e.co   = co;
        e.lat  = (o >= 4'hA && o <= 4'hD) ? W + 1 : 1;
        e.acc  = cyc;
        e.name = name;
        q.push_back(e);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            fail_now("drain");
            q.delete();
            seen = 1'b0;
        end
    endtask

    task automatic run(input string name, input logic [3:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] r,
                       input logic z, input logic ov, input logic co);
        issue(name, o, x, y, r, z, ov, co);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset out_valid", out_valid, 0);
        chk("reset Result", result, 0);
        chk("reset Zero", zero, 0);
        chk("reset Overflow", ovf, 0);
        chk("reset CarryOut", cout, 0);
        chk("reset in_ready", in_ready, 1);

        //   name          op     A             B             Result        Z  V  C
        run("add_ovf",    4'h2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1, 0);
        run("add_carry",  4'h2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, 1);
        run("sub_borrow", 4'h6, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 0, 0, 1);
        run("sub_minneg", 4'h6, 32'h00000000, 32'h80000000, 32'h80000000, 0, 1, 1);
        run("slt",        4'h7, 32'h80000000, 32'h00000001, 32'h00000001, 0, 0, 0);
        run("sltu",       4'h9, 32'h80000000, 32'h00000001, 32'h00000000, 1, 0, 0);
        run("sra",        4'h4, 32'h00000004, 32'h80000000, 32'hF8000000, 0, 0, 0);
        run("sll",        4'h3, 32'h00000021, 32'h00000001, 32'h00000002, 0, 0, 0);
        run("srl",        4'h5, 32'h0000001F, 32'h80000000, 32'h00000001, 0, 0, 0);
        run("and",        4'h0, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 0, 0, 0);
        run("or",         4'h1, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 0, 0, 0);
        run("xor",        4'h8, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 0, 0, 0);
        run("reserved",   4'hE, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1, 0, 0);
        run("mul",        4'hA, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 0, 0, 0);
        run("mulhu",      4'hB, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 0, 0, 0);
        run("divu",       4'hC, 32'd100,      32'd7,        32'd14,       0, 0, 0);
        run("remu",       4'hD, 32'd100,      32'd7,        32'd2,        0, 0, 0);
        run("divu_by0",   4'hC, 32'd5,        32'd0,        32'hFFFFFFFF, 0, 0, 0);
        run("remu_by0",   4'hD, 32'd5,        32'd0,        32'd5,        0, 0, 0);
        run("remu_zero",  4'hD, 32'd14,       32'd7,        32'd0,        1, 0, 0);

        // Backpressure: result held for 5 extra cycles in DONE.
        out_ready = 1'b0;
        issue("bp_add", 4'h2, 32'd1, 32'd1, 32'd2, 0, 0, 0);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("bp_add out_valid");
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Reset during an in-flight divide discards it.
        issue("divu_reset", 4'hC, 32'd100, 32'd7, 32'd14, 0, 0, 0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        seen = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset out_valid", out_valid, 0);
        chk("midreset Result", result, 0);
        rst = 1'b0;
        chk("postreset in_ready", in_ready, 1);
        run("add_after_rst", 4'h2, 32'd2, 32'd3, 32'd5, 0, 0, 0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor to the single-cycle datapath ALU. It keeps the existing 4-bit ALUop encoding, operand convention and flags, and adds SLTU plus iterative unsigned multiply/divide. Results are registered and delivered over a valid/ready interface. It sits between the decode/operand stage and writeback, and lets the multi-cycle core stall on long-latency ops.

Parameters:
DATA_WIDTH, 32, operand/result width (>=8, power of two)
SHAMT_W, $clog2(DATA_WIDTH), shift-amount width (localparam, derived)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operation request
in_ready  output  1  block can accept a request
A  input  DATA_WIDTH  operand A; also the shift amount for shifts
B  input  DATA_WIDTH  operand B; the value shifted for shifts
ALUop  input  4  operation select
out_valid  output  1  Result and flags are valid
out_ready  input  1  consumer accepts the result
Result  output  DATA_WIDTH  registered result
Zero  output  1  Result == 0
Overflow  output  1  signed overflow (ADD/SUB only)
CarryOut  output  1  ADD: carry out of MSB; SUB: borrow (A <u B); else 0

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous, active-high.
- Reset values: state IDLE; out_valid=0; Result=0; Zero=0; Overflow=0; CarryOut=0; in_ready=1 in the cycle after rst deasserts. Reset wins over every other event, including mid-BUSY. Any in-flight op is discarded and no result is produced.
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 SLL, 0100 SRA, 0101 SRL, 0110 SUB, 0111 SLT (signed), 1000 XOR, 1001 SLTU.
  - 1010 MUL (low DATA_WIDTH bits), 1011 MULHU (high bits, unsigned), 1100 DIVU, 1101 REMU.
  - 1110/1111: Result=0, single-cycle.
- Shifts: B is shifted by A[SHAMT_W-1:0]. SRA fills with B[MSB].
- SLT/SLTU: Result = {0..., flag}.
- Flags apply to ADD and SUB only: Overflow uses the true signed condition; SUB with B = most-negative value is included. For all other ops Overflow=0 and CarryOut=0.
- Zero is computed from the registered Result for every op.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid, latch A, B and ALUop.
    - Single-cycle ops (incl. reserved codes): go to DONE; out_valid=1 on the next cycle, so latency is 1.
    - MUL/MULHU/DIVU/REMU: go to BUSY, with counter = DATA_WIDTH.
  - BUSY: in_ready=0. One iteration per cycle; counter decrements; at counter == 1, go to DONE.
    - Multiply: shift-add over a 2*DATA_WIDTH accumulator.
    - Divide: restoring, one quotient bit per cycle.
    - out_valid rises exactly DATA_WIDTH+1 cycles after the accept edge.
  - DONE: out_valid=1, in_ready=0. Result and flags stay stable until out_ready=1. In the out_valid && out_ready cycle, go to IDLE; out_valid=0 on the next cycle.
- No accept in DONE, even with out_ready=1 in the same cycle; back-to-back throughput is one op per 2 cycles minimum.
- Division by zero: DIVU -> all ones; REMU -> A. Latency is the same (DATA_WIDTH+1); no exception.
- Inputs A, B and ALUop are ignored when in_valid=0 or in_ready=0; they are not sampled after the accept edge.
- in_valid held high during BUSY/DONE is not accepted until the return to IDLE. The requester holds it with unchanged operands.

Test Plan:
- Overflow: ADD A=0x7FFFFFFF, B=1 -> Result=0x80000000, Overflow=1, CarryOut=0, Zero=0, out_valid 1 cycle after accept. ADD 0xFFFFFFFF+1 -> Result=0, CarryOut=1, Zero=1.
- SUB/compare:
  - SUB 0-1 -> 0xFFFFFFFF, CarryOut=1, Overflow=0.
  - SUB 0 - 0x80000000 -> Overflow=1.
  - SLT A=0x80000000, B=1 -> 1; SLTU same operands -> 0.
- Shifts: SRA A=4, B=0x80000000 -> 0xF8000000; SLL A=33, B=1 -> 2; SRL A=31, B=0x80000000 -> 1.
- Multiply: MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE; MULHU same operands -> 1. out_valid exactly 33 cycles after accept; in_ready=0 throughout.
- Divide:
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - REMU 14/7 -> 0, Zero=1.
- Backpressure/reset:
  - Hold out_ready=0 for 5 cycles in DONE -> Result/flags unchanged, in_ready=0.
  - Assert rst 10 cycles into a DIVU -> next cycle out_valid=0, Result=0; then in_ready=1 and a new ADD 2+3 returns 5.
